// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, round counts,
// key-expansion FSM states and the GF(2^8) xtime helper.
package aes_pkg;

   localparam logic AES_128_BIT_KEY = 1'b0;
   localparam logic AES_256_BIT_KEY = 1'b1;

   localparam logic [3:0] AES128_ROUNDS = 4'ha;
   localparam logic [3:0] AES256_ROUNDS = 4'he;

   typedef enum logic [1:0] {
      KEY_IDLE = 2'd0,
      KEY_INIT = 2'd1,
      KEY_GEN  = 2'd2
   } key_state_e;

   // Multiply by x in GF(2^8); also advances rcon.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Four parallel forward AES S-boxes on one 32-bit word.
// Ports: sword (in, 32) word to substitute; new_sword (out, 32).
module aes_sbox
   import aes_pkg::*;
(
   input  logic [31:0] sword,
   output logic [31:0] new_sword
);

   function automatic logic [7:0] gf_mul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 = a^2 * a^4 * ... * a^128
   // (0 maps to 0), then the affine map.
   function automatic logic [7:0] sub_byte(
      input logic [7:0] a
   );
      logic [7:0] p;
      logic [7:0] v;
      p = a;
      v = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gf_mul(p, p);
         v = gf_mul(v, p);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
               ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
               ^ 8'h63;
   endfunction

   always_comb begin
      new_sword = {sub_byte(sword[31:24]),
                   sub_byte(sword[23:16]),
                   sub_byte(sword[15:8]),
                   sub_byte(sword[7:0])};
   end

endmodule

// File: rtl/aes_dec_key_mem.sv
// AES-128/256 round-key expander and key file for the decipher.
// Ports: clk, reset (sync, high), init, key[255:0], keylen,
// round[3:0] -> round_key[127:0] (comb), ready.
// Option AES_KEY_ZEROIZE_EN adds input zeroize (wipe all keys).
module aes_dec_key_mem
   import aes_pkg::*;
#(
   parameter int MAX_ROUNDS = 14,
   parameter bit OOR_ZERO   = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
`ifdef AES_KEY_ZEROIZE_EN
   input  logic         zeroize,
`endif
   input  logic         init,
   input  logic [255:0] key,
   input  logic         keylen,
   input  logic [3:0]   round,
   output logic [127:0] round_key,
   output logic         ready
);

   key_state_e   state;
   key_state_e   state_n;
   logic [127:0] rk [0:MAX_ROUNDS];
   logic [255:0] key_r;
   logic         keylen_r;
   logic [7:0]   rcon;
   logic [3:0]   gen_ctr;
   logic [3:0]   last_idx;
   logic         wipe;

   logic [127:0] prev;
   logic [127:0] base;
   logic [31:0]  sub_out;
   logic [31:0]  t;
   logic         use_rot;
   logic [31:0]  w0, w1, w2, w3;

`ifdef AES_KEY_ZEROIZE_EN
   assign wipe = zeroize;
`else
   assign wipe = 1'b0;
`endif

   assign last_idx = (keylen_r == AES_256_BIT_KEY) ?
                     AES256_ROUNDS : AES128_ROUNDS;
   assign ready = (state == KEY_IDLE);

   // Sbox input is always the last word of the previous key;
   // RotWord commutes with SubWord, so it is applied after.
   assign prev = rk[gen_ctr - 4'd1];
   assign base = keylen_r ? rk[gen_ctr - 4'd2] : prev;
   assign use_rot = !keylen_r || !gen_ctr[0];

   aes_sbox u_sbox (
      .sword     (prev[31:0]),
      .new_sword (sub_out)
   );

   always_comb begin
      t = sub_out;
      if (use_rot)
         t = {sub_out[23:0], sub_out[31:24]} ^ {rcon, 24'h0};
      w0 = base[127:96] ^ t;
      w1 = base[95:64]  ^ w0;
      w2 = base[63:32]  ^ w1;
      w3 = base[31:0]   ^ w2;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         KEY_IDLE: if (init) state_n = KEY_INIT;
         KEY_INIT: state_n = KEY_GEN;
         KEY_GEN:  if (gen_ctr == last_idx) state_n = KEY_IDLE;
         default:  state_n = KEY_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || wipe) begin
         state    <= KEY_IDLE;
         key_r    <= '0;
         keylen_r <= AES_128_BIT_KEY;
         gen_ctr  <= 4'd0;
         rcon     <= reset ? 8'h01 : 8'h00;
         for (int i = 0; i <= MAX_ROUNDS; i++)
            rk[i] <= '0;
      end else begin
         state <= state_n;
         unique case (state)
            KEY_IDLE: begin
               if (init) begin
                  key_r    <= key;
                  keylen_r <= keylen;
               end
            end
            KEY_INIT: begin
               rk[0] <= key_r[255:128];
               if (keylen_r) rk[1] <= key_r[127:0];
               rcon    <= 8'h01;
               gen_ctr <= keylen_r ? 4'd2 : 4'd1;
            end
            KEY_GEN: begin
               rk[gen_ctr] <= {w0, w1, w2, w3};
               gen_ctr     <= gen_ctr + 4'd1;
               if (use_rot) rcon <= xtime(rcon);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      round_key = '0;
      if (round <= last_idx)
         round_key = rk[round];
      else if (!OOR_ZERO)
         round_key = rk[last_idx];
   end

endmodule

// File: tb/tb_aes_dec_key_mem.sv
// Self-checking bench for aes_dec_key_mem with FIPS-197
// vectors; round reads go through an expected-value queue.
module tb_aes_dec_key_mem;

   logic         clk = 1'b0;
   logic         reset;
`ifdef AES_KEY_ZEROIZE_EN
   logic         zeroize;
`endif
   logic         init;
   logic [255:0] key;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic         ready;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      string        tag;
      logic [3:0]   idx;
      logic [127:0] exp;
   } rd_t;

   rd_t sb_q[$];

   localparam logic [255:0] K128 =
      {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
   localparam logic [255:0] K256 =
      256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
   localparam logic [255:0] KBAD =
      256'hdeadbeef_01234567_89abcdef_cafef00d_11111111_22222222_33333333_44444444;

   localparam logic [127:0] A128_R0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] A128_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
   localparam logic [127:0] A128_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [127:0] A256_R0  = 128'h603deb10_15ca71be_2b73aef0_857d7781;
   localparam logic [127:0] A256_R1  = 128'h1f352c07_3b6108d7_2d9810a3_0914dff4;
   localparam logic [127:0] A256_R2  = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde;
   localparam logic [127:0] A256_R14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

   aes_dec_key_mem dut (
      .clk       (clk),
      .reset     (reset),
`ifdef AES_KEY_ZEROIZE_EN
      .zeroize   (zeroize),
`endif
      .init      (init),
      .key       (key),
      .keylen    (keylen),
      .round     (round),
      .round_key (round_key),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   task automatic chk(
      input string        tag,
      input logic [127:0] got,
      input logic [127:0] exp
   );
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(
      input string        tag,
      input logic [3:0]   idx,
      input logic [127:0] exp
   );
      rd_t e;
      e.tag = tag;
      e.idx = idx;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      rd_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         round = e.idx;
         #1;
         chk(e.tag, round_key, e.exp);
      end
   endtask

   // Start an expansion; cycle 0 is the cycle init is high.
   // Returns the first cycle in which ready is seen high.
   // A nonzero pulse_at re-drives init with KBAD in that cycle.
   task automatic run_init(
      input  logic [255:0] k,
      input  logic         kl,
      input  int           pulse_at,
      output int           cycles
   );
      @(posedge clk); #1;
      key = k;
      keylen = kl;
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      cycles = 1;
      while (!ready && cycles < 40) begin
         if (pulse_at != 0 && cycles == pulse_at) begin
            init = 1'b1;
            key = KBAD;
            keylen = 1'b0;
         end
         @(posedge clk); #1;
         init = 1'b0;
         cycles++;
      end
   endtask

   int cyc;

   initial begin
      reset = 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      init = 1'b0;
      key = '0;
      keylen = 1'b0;
      round = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_ready", {127'h0, ready}, 128'h1);
      push("rst_r0", 4'd0, 128'h0);
      push("rst_r11", 4'd11, 128'h0);
      drain();

      // AES-128
      run_init(K128, 1'b0, 0, cyc);
      chk("a128_lat", 128'(cyc), 128'd12);
      push("a128_r0", 4'd0, A128_R0);
      push("a128_r1", 4'd1, A128_R1);
      push("a128_r10", 4'd10, A128_R10);
      push("a128_r11", 4'd11, 128'h0);
      push("a128_r15", 4'd15, 128'h0);
      drain();

      // AES-256
      run_init(K256, 1'b1, 0, cyc);
      chk("a256_lat", 128'(cyc), 128'd15);
      push("a256_r0", 4'd0, A256_R0);
      push("a256_r1", 4'd1, A256_R1);
      push("a256_r2", 4'd2, A256_R2);
      push("a256_r14", 4'd14, A256_R14);
      push("a256_r15", 4'd15, 128'h0);
      drain();

      // init during expansion must be ignored
      run_init(K256, 1'b1, 5, cyc);
      chk("ign_lat", 128'(cyc), 128'd15);
      push("ign_r2", 4'd2, A256_R2);
      push("ign_r14", 4'd14, A256_R14);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("ign_idle", {127'h0, ready}, 128'h1);

      // AES-128 over a file still holding AES-256 keys 11..14
      run_init(K128, 1'b0, 0, cyc);
      chk("k4_lat", 128'(cyc), 128'd12);
      keylen = 1'b1;
      key = KBAD;
      @(posedge clk); #1;
      push("k4_r10", 4'd10, A128_R10);
      push("k4_r12", 4'd12, 128'h0);
      push("k4_r1", 4'd1, A128_R1);
      drain();

      // reset mid-expansion
      @(posedge clk); #1;
      key = K256;
      keylen = 1'b1;
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rmid_ready", {127'h0, ready}, 128'h1);
      push("rmid_r0", 4'd0, 128'h0);
      push("rmid_r1", 4'd1, 128'h0);
      drain();

`ifdef AES_KEY_ZEROIZE_EN
      run_init(K128, 1'b0, 0, cyc);
      chk("z_lat", 128'(cyc), 128'd12);
      @(posedge clk); #1;
      zeroize = 1'b1;
      init = 1'b1;
      key = K256;
      keylen = 1'b1;
      @(posedge clk); #1;
      zeroize = 1'b0;
      init = 1'b0;
      chk("z_ready", {127'h0, ready}, 128'h1);
      push("z_r0", 4'd0, 128'h0);
      push("z_r1", 4'd1, 128'h0);
      push("z_r10", 4'd10, 128'h0);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("z_ready2", {127'h0, ready}, 128'h1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
